// File: rtl/uartm_msg_handler.sv
// ASCII "wm <addr> <data>" / "rm <addr>" command decoder driving a 32-bit register-bus master.
// Latency: reg_cs rises the cycle after the terminator is popped; first response byte the cycle after reg_ack or timeout.
// Backpressure: parsing stalls while rx_data_avail is low; the response stalls (tx_data held) while tx_fifo_full is high.
//
// Ports: app_clk/app_rst (async active-high), RX FIFO pop side (rx_data_avail, rx_data, rx_rd),
// TX FIFO push side (tx_fifo_full, tx_wr, tx_data), register bus (reg_cs, reg_wr, reg_addr,
// reg_wdata, reg_be, reg_rdata, reg_ack).
// Optional build macro UARTM_ECHO_EN: echo every popped RX byte into the TX FIFO in the same cycle.
module uartm_msg_handler #(
    parameter int RSP_TIMEOUT = 1024
) (
    input  logic        app_clk,
    input  logic        app_rst,
    input  logic        rx_data_avail,
    input  logic [7:0]  rx_data,
    output logic        rx_rd,
    input  logic        tx_fifo_full,
    output logic        tx_wr,
    output logic [7:0]  tx_data,
    output logic        reg_cs,
    output logic        reg_wr,
    output logic [31:0] reg_addr,
    output logic [31:0] reg_wdata,
    output logic [3:0]  reg_be,
    input  logic [31:0] reg_rdata,
    input  logic        reg_ack
);

    localparam int TW = $clog2(RSP_TIMEOUT + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CMD   = 3'd1;
    localparam logic [2:0] S_SEP   = 3'd2;
    localparam logic [2:0] S_ADDR  = 3'd3;
    localparam logic [2:0] S_DATA  = 3'd4;
    localparam logic [2:0] S_FLUSH = 3'd5;
    localparam logic [2:0] S_BUS   = 3'd6;
    localparam logic [2:0] S_RESP  = 3'd7;

    localparam logic [1:0] R_OK = 2'd0;
    localparam logic [1:0] R_ER = 2'd1;
    localparam logic [1:0] R_TO = 2'd2;
    localparam logic [1:0] R_RD = 2'd3;

    logic [2:0]    state;
    logic          op_wr;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rdata_q;
    logic [3:0]    dig_cnt;
    logic [TW-1:0] to_cnt;
    logic [1:0]    rsp_kind;
    logic [3:0]    rsp_idx;

    logic          parse_st;
    logic          pop;
    logic          is_term;
    logic          is_sp;
    logic          hex_vld;
    logic [3:0]    hex_nib;
    logic [2:0]    err_state;
    logic [7:0]    rsp_byte;
    logic          rsp_last;
    logic [31:0]   rd_shift;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
    endfunction

    assign parse_st = (state != S_BUS) && (state != S_RESP);
`ifdef UARTM_ECHO_EN
    // The echo shares the TX FIFO, so a byte is only popped when it can also be echoed.
    assign pop = parse_st && rx_data_avail && !tx_fifo_full;
`else
    assign pop = parse_st && rx_data_avail;
`endif

    assign is_term = (rx_data == 8'h0a) || (rx_data == 8'h0d);
    assign is_sp   = (rx_data == 8'h20);

    always_comb begin
        hex_vld = 1'b0;
        hex_nib = 4'h0;
        if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
            hex_vld = 1'b1;
            hex_nib = rx_data[3:0];
        end else if ((rx_data >= 8'h61 && rx_data <= 8'h66) || (rx_data >= 8'h41 && rx_data <= 8'h46)) begin
            hex_vld = 1'b1;
            hex_nib = rx_data[3:0] + 4'd9;
        end
    end

    // A syntax error on the terminator itself answers immediately; otherwise discard up to the terminator.
    assign err_state = is_term ? S_RESP : S_FLUSH;

    assign rd_shift = rdata_q << {rsp_idx[2:0], 2'b00};

    always_comb begin
        rsp_byte = 8'h0a;
        case (rsp_kind)
            R_OK: if (rsp_idx == 4'd0) rsp_byte = 8'h6f; else if (rsp_idx == 4'd1) rsp_byte = 8'h6b;
            R_ER: if (rsp_idx == 4'd0) rsp_byte = 8'h65; else if (rsp_idx == 4'd1) rsp_byte = 8'h72;
            R_TO: if (rsp_idx == 4'd0) rsp_byte = 8'h74; else if (rsp_idx == 4'd1) rsp_byte = 8'h6f;
            default: if (rsp_idx < 4'd8) rsp_byte = hex_char(rd_shift[31:28]);
        endcase
    end

    assign rsp_last = (rsp_kind == R_RD) ? (rsp_idx == 4'd8) : (rsp_idx == 4'd2);

    assign rx_rd = pop;
`ifdef UARTM_ECHO_EN
    assign tx_wr   = ((state == S_RESP) && !tx_fifo_full) || pop;
    assign tx_data = (state == S_RESP) ? rsp_byte : (pop ? rx_data : 8'h00);
`else
    assign tx_wr   = (state == S_RESP) && !tx_fifo_full;
    assign tx_data = (state == S_RESP) ? rsp_byte : 8'h00;
`endif

    assign reg_cs    = (state == S_BUS);
    assign reg_wr    = op_wr;
    assign reg_addr  = addr_q;
    assign reg_wdata = wdata_q;
    assign reg_be    = {4{reg_cs}};

    always_ff @(posedge app_clk or posedge app_rst) begin
        if (app_rst) begin
            state    <= S_IDLE;
            op_wr    <= 1'b0;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            rdata_q  <= 32'h0;
            dig_cnt  <= 4'd0;
            to_cnt   <= '0;
            rsp_kind <= R_OK;
            rsp_idx  <= 4'd0;
        end else begin
            case (state)
                S_IDLE: if (pop) begin
                    if (rx_data == 8'h77 || rx_data == 8'h72) begin
                        op_wr <= (rx_data == 8'h77);
                        state <= S_CMD;
                    end else if (!is_sp && !is_term) begin
                        state <= S_FLUSH;
                    end
                end
                S_CMD: if (pop) begin
                    if (rx_data == 8'h6d) state <= S_SEP;
                    else begin state <= err_state; rsp_kind <= R_ER; rsp_idx <= 4'd0; end
                end
                S_SEP: if (pop) begin
                    if (is_sp) begin
                        state   <= S_ADDR;
                        addr_q  <= 32'h0;
                        dig_cnt <= 4'd0;
                    end else begin state <= err_state; rsp_kind <= R_ER; rsp_idx <= 4'd0; end
                end
                S_ADDR: if (pop) begin
                    if (hex_vld && dig_cnt != 4'd8) begin
                        addr_q  <= {addr_q[27:0], hex_nib};
                        dig_cnt <= dig_cnt + 4'd1;
                    end else if (is_sp && dig_cnt == 4'd0) begin
                        state <= S_ADDR;
                    end else if (is_sp && op_wr) begin
                        state   <= S_DATA;
                        wdata_q <= 32'h0;
                        dig_cnt <= 4'd0;
                    end else if (is_term && dig_cnt != 4'd0 && !op_wr) begin
                        state  <= S_BUS;
                        to_cnt <= '0;
                    end else begin state <= err_state; rsp_kind <= R_ER; rsp_idx <= 4'd0; end
                end
                S_DATA: if (pop) begin
                    if (hex_vld && dig_cnt != 4'd8) begin
                        wdata_q <= {wdata_q[27:0], hex_nib};
                        dig_cnt <= dig_cnt + 4'd1;
                    end else if (is_sp && dig_cnt == 4'd0) begin
                        state <= S_DATA;
                    end else if (is_term && dig_cnt != 4'd0) begin
                        state  <= S_BUS;
                        to_cnt <= '0;
                    end else begin state <= err_state; rsp_kind <= R_ER; rsp_idx <= 4'd0; end
                end
                S_FLUSH: if (pop && is_term) begin
                    state    <= S_RESP;
                    rsp_kind <= R_ER;
                    rsp_idx  <= 4'd0;
                end
                S_BUS: begin
                    // reg_ack is checked first so an ack on the expiry cycle still counts as success.
                    if (reg_ack) begin
                        state    <= S_RESP;
                        rdata_q  <= reg_rdata;
                        rsp_kind <= op_wr ? R_OK : R_RD;
                        rsp_idx  <= 4'd0;
                    end else if (to_cnt == TW'(RSP_TIMEOUT - 1)) begin
                        state    <= S_RESP;
                        rsp_kind <= R_TO;
                        rsp_idx  <= 4'd0;
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                    end
                end
                default: if (!tx_fifo_full) begin
                    if (rsp_last) state <= S_IDLE;
                    else rsp_idx <= rsp_idx + 4'd1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uartm_msg_handler.sv
// Self-checking bench for uartm_msg_handler: RX FIFO model, register-bus responder,
// and a TX byte scoreboard fed with the expected response of every command sent.
module tb_uartm_msg_handler;

    logic        app_clk = 1'b0;
    logic        app_rst = 1'b1;
    logic        rx_data_avail = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_rd;
    logic        tx_fifo_full = 1'b0;
    logic        tx_wr;
    logic [7:0]  tx_data;
    logic        reg_cs;
    logic        reg_wr;
    logic [31:0] reg_addr;
    logic [31:0] reg_wdata;
    logic [3:0]  reg_be;
    logic [31:0] reg_rdata = 32'h0;
    logic        reg_ack = 1'b0;

    always #5 app_clk = ~app_clk;

    uartm_msg_handler #(.RSP_TIMEOUT(1024)) dut (
        .app_clk       (app_clk),
        .app_rst       (app_rst),
        .rx_data_avail (rx_data_avail),
        .rx_data       (rx_data),
        .rx_rd         (rx_rd),
        .tx_fifo_full  (tx_fifo_full),
        .tx_wr         (tx_wr),
        .tx_data       (tx_data),
        .reg_cs        (reg_cs),
        .reg_wr        (reg_wr),
        .reg_addr      (reg_addr),
        .reg_wdata     (reg_wdata),
        .reg_be        (reg_be),
        .reg_rdata     (reg_rdata),
        .reg_ack       (reg_ack)
    );

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          dly;
    } bus_t;

    typedef struct {
        string       cmd;
        bit          bus;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          dly;
        string       rsp;
    } vec_t;

    logic [7:0] rx_q[$];
    logic [7:0] tx_exp[$];
    bus_t       bus_q[$];
    int         n_tests = 0;
    int         n_fail = 0;
    bit         toggle_full = 1'b0;
    int         last_cs_len = 0;
    vec_t       vecs[10];

    function automatic vec_t mk(input string c, input bit b, input bit w, input logic [31:0] a,
                                input logic [31:0] d, input logic [31:0] r, input int dl, input string rs);
        vec_t v;
        v.cmd = c; v.bus = b; v.wr = w; v.addr = a; v.wdata = d; v.rdata = r; v.dly = dl; v.rsp = rs;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // RX FIFO model and TX scoreboard: sample at negedge, update FIFO state just after posedge.
    initial begin
        bit       pop;
        logic [7:0] e;
        forever begin
            @(negedge app_clk);
            pop = rx_rd;
            if (rx_rd) begin
                n_tests++;
                if (!rx_data_avail) begin
                    n_fail++;
                    $display("FAIL rx_rd_when_empty: got rx_rd=1 expected 0");
                end
            end
            if (tx_wr) begin
                n_tests++;
                if (tx_fifo_full) begin
                    n_fail++;
                    $display("FAIL tx_wr_while_full: got tx_wr=1 expected 0 (byte %0h)", tx_data);
                end else if (tx_exp.size() == 0) begin
                    n_fail++;
                    $display("FAIL tx_unexpected: got byte %0h expected none", tx_data);
                end else begin
                    e = tx_exp.pop_front();
                    if (tx_data !== e) begin
                        n_fail++;
                        $display("FAIL tx_byte: got %0h expected %0h", tx_data, e);
                    end
                end
            end
            @(posedge app_clk);
            #1;
            if (pop && rx_q.size() != 0) void'(rx_q.pop_front());
            rx_data_avail = (rx_q.size() != 0);
            rx_data       = rx_data_avail ? rx_q[0] : 8'h00;
            tx_fifo_full  = toggle_full ? ~tx_fifo_full : 1'b0;
        end
    end

    // Register-bus responder: checks each transaction against bus_q and acks after dly cycles (dly<0: never).
    initial begin
        bit   active;
        bit   acked;
        int   cnt;
        int   len;
        bus_t cur;
        active = 1'b0; acked = 1'b0; cnt = -1; len = 0;
        cur.wr = 1'b0; cur.addr = '0; cur.wdata = '0; cur.rdata = '0; cur.dly = -1;
        forever begin
            @(negedge app_clk);
            if (acked) begin
                n_tests++;
                if (reg_cs !== 1'b0) begin
                    n_fail++;
                    $display("FAIL cs_after_ack: got reg_cs=%b expected 0", reg_cs);
                end
                acked = 1'b0;
            end
            reg_ack = 1'b0;
            if (reg_cs && !active) begin
                active = 1'b1;
                len = 0;
                n_tests++;
                if (bus_q.size() == 0) begin
                    n_fail++;
                    cnt = -1;
                    $display("FAIL bus_unexpected: got reg_cs with addr %0h expected no transaction", reg_addr);
                end else begin
                    cur = bus_q.pop_front();
                    cnt = cur.dly;
                    if (reg_wr !== cur.wr || reg_addr !== cur.addr || reg_be !== 4'hf ||
                        (cur.wr && reg_wdata !== cur.wdata)) begin
                        n_fail++;
                        $display("FAIL bus_txn: got wr=%b addr=%0h wdata=%0h be=%0h expected wr=%b addr=%0h wdata=%0h be=f",
                                 reg_wr, reg_addr, reg_wdata, reg_be, cur.wr, cur.addr, cur.wdata);
                    end
                end
            end
            if (active && !reg_cs) begin
                active = 1'b0;
                last_cs_len = len;
            end
            if (active) begin
                len++;
                if (cnt == 0) begin
                    reg_ack   = 1'b1;
                    reg_rdata = cur.rdata;
                    acked     = 1'b1;
                    cnt       = -1;
                end else if (cnt > 0) begin
                    cnt--;
                end
            end
        end
    end

    task automatic run_cmd(input vec_t v, input int budget);
        bus_t b;
        int   k;
        bit   busy;
        for (int i = 0; i < v.cmd.len(); i++) rx_q.push_back(v.cmd[i]);
        for (int i = 0; i < v.rsp.len(); i++) tx_exp.push_back(v.rsp[i]);
        if (v.bus) begin
            b.wr = v.wr; b.addr = v.addr; b.wdata = v.wdata; b.rdata = v.rdata; b.dly = v.dly;
            bus_q.push_back(b);
        end
        k = 0;
        busy = 1'b1;
        while (busy && k < budget) begin
            @(negedge app_clk);
            k++;
            busy = (rx_q.size() != 0) || (tx_exp.size() != 0) || (bus_q.size() != 0) || reg_cs;
        end
        n_tests++;
        if (busy) begin
            n_fail++;
            $display("FAIL cmd_done %s: got rx=%0d tx=%0d bus=%0d left expected all 0",
                     v.cmd, rx_q.size(), tx_exp.size(), bus_q.size());
            rx_q.delete(); tx_exp.delete(); bus_q.delete();
        end
        repeat (3) @(negedge app_clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   k;
        bus_t b;
        vecs[0] = mk("wm 30020058 11223344\n", 1, 1, 32'h30020058, 32'h11223344, 32'h0, 3, "ok\n");
        vecs[1] = mk("rm 30020058\015",        1, 0, 32'h30020058, 32'h0, 32'h11223344, 3, "11223344\n");
        vecs[2] = mk("wm  3080000   1\n",      1, 1, 32'h03080000, 32'h00000001, 32'h0, 1, "ok\n");
        vecs[3] = mk("xm 1\n",                 0, 0, 32'h0, 32'h0, 32'h0, 0, "er\n");
        vecs[4] = mk("rm 123456789\n",         0, 0, 32'h0, 32'h0, 32'h0, 0, "er\n");
        vecs[5] = mk("wm 10\n",                0, 0, 32'h0, 32'h0, 32'h0, 0, "er\n");
        vecs[6] = mk("rm 0\n",                 1, 0, 32'h0, 32'h0, 32'hdeadbeef, 0, "deadbeef\n");
        vecs[7] = mk("rm aBcD\n",              1, 0, 32'h0000abcd, 32'h0, 32'h0000f00d, 1, "0000f00d\n");
        vecs[8] = mk("wm ffffffff 0\015",      1, 1, 32'hffffffff, 32'h0, 32'h0, 2, "ok\n");
        vecs[9] = mk("rm 1 \n",                0, 0, 32'h0, 32'h0, 32'h0, 0, "er\n");

        repeat (3) @(negedge app_clk);
        chk("rst_rx_rd", {63'h0, rx_rd}, 64'h0);
        chk("rst_tx_wr", {63'h0, tx_wr}, 64'h0);
        chk("rst_tx_data", {56'h0, tx_data}, 64'h0);
        chk("rst_reg_cs", {63'h0, reg_cs}, 64'h0);
        chk("rst_reg_wr", {63'h0, reg_wr}, 64'h0);
        chk("rst_reg_addr", {32'h0, reg_addr}, 64'h0);
        chk("rst_reg_wdata", {32'h0, reg_wdata}, 64'h0);
        chk("rst_reg_be", {60'h0, reg_be}, 64'h0);
        app_rst = 1'b0;
        repeat (2) @(negedge app_clk);

        for (int i = 0; i < 10; i++) run_cmd(vecs[i], 3000);

        // No ack: bus held exactly RSP_TIMEOUT cycles, then "to".
        run_cmd(mk("rm 0\n", 1, 0, 32'h0, 32'h0, 32'h0, -1, "to\n"), 3000);
        chk("timeout_cs_len", 64'(last_cs_len), 64'd1024);

        // TX FIFO full every other cycle during a 9-byte read response.
        toggle_full = 1'b1;
        run_cmd(mk("rm 4\n", 1, 0, 32'h4, 32'h0, 32'h9abcdef0, 1, "9abcdef0\n"), 3000);
        toggle_full = 1'b0;
        repeat (2) @(negedge app_clk);

        // Reset while the bus request is outstanding.
        for (int i = 0; i < 5; i++) rx_q.push_back(vecs[6].cmd[i]);
        b.wr = 1'b0; b.addr = 32'h0; b.wdata = 32'h0; b.rdata = 32'h0; b.dly = -1;
        bus_q.push_back(b);
        k = 0;
        while (!reg_cs && k < 200) begin
            @(negedge app_clk);
            k++;
        end
        chk("rst_bus_cs_seen", {63'h0, reg_cs}, 64'h1);
        repeat (5) @(negedge app_clk);
        #2;
        app_rst = 1'b1;
        #1;
        chk("midrst_reg_cs", {63'h0, reg_cs}, 64'h0);
        chk("midrst_reg_be", {60'h0, reg_be}, 64'h0);
        chk("midrst_tx_wr", {63'h0, tx_wr}, 64'h0);
        chk("midrst_reg_addr", {32'h0, reg_addr}, 64'h0);
        @(negedge app_clk);
        @(negedge app_clk);
        app_rst = 1'b0;
        repeat (2) @(negedge app_clk);
        chk("midrst_cs_len", 64'(last_cs_len), 64'd6);
        chk("midrst_bus_q_empty", 64'(bus_q.size()), 64'd0);

        run_cmd(mk("rm 0\n", 1, 0, 32'h0, 32'h0, 32'h00c0ffee, 2, "00c0ffee\n"), 3000);
        run_cmd(mk("wm 5 a\n", 1, 1, 32'h5, 32'ha, 32'h0, 0, "ok\n"), 3000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
